// File: rtl/serial_frame_tx.sv
// serial_frame_tx
//   Moore-style serial frame transmitter. Each accepted request emits
//   START(1), DATA_W payload bits MSB first, an optional even-parity bit,
//   and STOP(0). A new request may be accepted in STOP for back-to-back
//   frames.
//
// Ports
//   clk    in   1       rising-edge clock
//   rst    in   1       asynchronous, active-low reset
//   start  in   1       frame request, sampled on the rising edge
//   din    in   DATA_W  payload, captured on the accepting edge
//   ready  out  1       a start on the next edge will be accepted
//   x      out  1       serial line
//   done   out  1       high during the STOP cycle of each frame
module serial_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              x,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  state_t            next;
  logic [DATA_W-1:0] sr;
  logic [CW-1:0]     cnt;
  logic              par;
  logic              load;

  // A request is only honoured while the line is idle or finishing a frame.
  assign load = ((state == IDLE) || (state == STOP)) && start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    next = start ? START : IDLE;
      START:   next = DATA;
      DATA: begin
        if (cnt == LAST) next = (PARITY_EN != 0) ? PARITY : STOP;
        else             next = DATA;
      end
      PARITY:  next = STOP;
      STOP:    next = start ? START : IDLE;
      default: next = IDLE;
    endcase
  end

  // Parity is taken from din at capture time because the shift register
  // has been emptied by the time the parity cycle is reached.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr  <= '0;
      cnt <= '0;
      par <= 1'b0;
    end else if (load) begin
      sr  <= din;
      cnt <= '0;
      par <= ^din;
    end else if (state == DATA) begin
      sr  <= sr << 1;
      cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    x     = 1'b0;
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      START:   x = 1'b1;
      DATA:    x = sr[DATA_W-1];
      PARITY:  x = par;
      STOP: begin
        done  = 1'b1;
        ready = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] din;
  logic       x0, ready0, done0;
  logic       x1, ready1, done1;

  int errors = 0;
  int checks = 0;

  // Expected line contents per DUT: one entry per remaining frame cycle.
  bit q0[$];
  bit q1[$];

  serial_frame_tx #(.DATA_W(8), .PARITY_EN(1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .ready(ready0), .x(x0), .done(done0)
  );

  serial_frame_tx #(.DATA_W(8), .PARITY_EN(0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .ready(ready1), .x(x1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as transmitted, bit k = k-th line cycle after acceptance.
  function automatic logic [10:0] fvec(input logic [7:0] d, input bit pen);
    logic [10:0] v;
    v    = '0;
    v[0] = 1'b1;
    for (int i = 0; i < 8; i++) v[1+i] = d[7-i];
    if (pen) v[9] = ^d;
    return v;
  endfunction

  // Reference model: a frame is a list of line values; the line is free to
  // accept a new request when at most the STOP entry remains.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      bit r0, r1;
      logic [10:0] fv;
      r0 = (q0.size() <= 1);
      r1 = (q1.size() <= 1);
      if (q0.size() > 0) void'(q0.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (start && r0) begin
        fv = fvec(din, 1'b1);
        for (int k = 0; k < 11; k++) q0.push_back(fv[k]);
      end
      if (start && r1) begin
        fv = fvec(din, 1'b0);
        for (int k = 0; k < 10; k++) q1.push_back(fv[k]);
      end
    end
  end

  // Compare process: every falling edge, both DUTs against the model.
  always @(negedge clk) begin
    bit ex, er, ed;
    ex = (q0.size() > 0) ? q0[0] : 1'b0;
    ed = (q0.size() == 1);
    er = (q0.size() <= 1);
    chk("par.x", 32'(x0), 32'(ex));
    chk("par.ready", 32'(ready0), 32'(er));
    chk("par.done", 32'(done0), 32'(ed));
    ex = (q1.size() > 0) ? q1[0] : 1'b0;
    ed = (q1.size() == 1);
    er = (q1.size() <= 1);
    chk("nopar.x", 32'(x1), 32'(ex));
    chk("nopar.ready", 32'(ready1), 32'(er));
    chk("nopar.done", 32'(done1), 32'(ed));
  end

  // One-cycle start pulse, then record 11 cycles after the accepting edge.
  task automatic send(input logic [7:0] d, output logic [10:0] xt, output logic [10:0] dt,
                      output logic [10:0] rt, output logic [10:0] x1t, output logic [10:0] d1t);
    @(posedge clk); #2 start = 1'b1; din = d;
    @(posedge clk); #2 start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      xt[10-k]  = x0;
      dt[10-k]  = done0;
      rt[10-k]  = ready0;
      x1t[10-k] = x1;
      d1t[10-k] = done1;
    end
  endtask

  initial begin
    logic [10:0] xt, dt, rt, x1t, d1t, fv;
    logic [10:0] lit;
    int ndone;

    rst = 1'b0; start = 1'b0; din = '0;
    #1;
    chk("rst.x", 32'(x0), 0);
    chk("rst.ready", 32'(ready0), 1);
    chk("rst.done", 32'(done0), 0);
    @(posedge clk); #2 rst = 1'b1;

    // Pin the model against hand-derived frames.
    fv = fvec(8'hA5, 1'b1); lit = 11'b11010010100;
    for (int k = 0; k < 11; k++) chk("model.A5", 32'(fv[k]), 32'(lit[10-k]));
    fv = fvec(8'h01, 1'b1); lit = 11'b10000000110;
    for (int k = 0; k < 11; k++) chk("model.01", 32'(fv[k]), 32'(lit[10-k]));
    fv = fvec(8'hFF, 1'b1); lit = 11'b11111111100;
    for (int k = 0; k < 11; k++) chk("model.FF", 32'(fv[k]), 32'(lit[10-k]));

    // Idle line after reset.
    repeat (20) begin
      @(negedge clk);
      chk("idle.x", 32'(x0), 0);
      chk("idle.ready", 32'(ready0), 1);
      chk("idle.done", 32'(done0), 0);
    end

    send(8'hA5, xt, dt, rt, x1t, d1t);
    chk("A5.x", 32'(xt), 32'(11'b11010010100));
    chk("A5.done", 32'(dt), 32'(11'b00000000001));
    chk("A5.ready", 32'(rt), 32'(11'b00000000001));

    repeat (2) @(posedge clk);
    send(8'h01, xt, dt, rt, x1t, d1t);
    chk("01.x", 32'(xt), 32'(11'b10000000110));
    chk("01.nopar.x", 32'(x1t), 32'(11'b10000000100));
    chk("01.nopar.done", 32'(d1t), 32'(11'b00000000010));

    // Back-to-back: new request raised during STOP.
    repeat (2) @(posedge clk);
    @(posedge clk); #2 start = 1'b1; din = 8'hA5;
    @(posedge clk); #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 start = 1'b1; din = 8'h3C;
    @(negedge clk);
    chk("b2b.stop_done", 32'(done0), 1);
    @(posedge clk); #2 start = 1'b0; din = 8'h00;
    @(negedge clk);
    chk("b2b.start_x", 32'(x0), 1);
    chk("b2b.start_ready", 32'(ready0), 0);
    repeat (14) @(posedge clk);

    // start and din disturbed mid-frame: exactly one frame.
    @(posedge clk); #2 start = 1'b1; din = 8'hA5;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 start = 1'b1; din = 8'h5A;
    @(posedge clk); #2 start = 1'b0; din = 8'h00;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chk("midframe.frames", 32'(ndone), 1);

    // Reset during the 4th data bit.
    @(posedge clk); #2 start = 1'b1; din = 8'hF0;
    @(posedge clk); #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("abort.pre_x", 32'(x0), 1);
    rst = 1'b0;
    #1;
    chk("abort.x", 32'(x0), 0);
    chk("abort.ready", 32'(ready0), 1);
    chk("abort.done", 32'(done0), 0);
    @(posedge clk); #2 rst = 1'b1;
    send(8'hFF, xt, dt, rt, x1t, d1t);
    chk("FF.x", 32'(xt), 32'(11'b11111111100));
    chk("FF.done", 32'(dt), 32'(11'b00000000001));

    // Randomized traffic with occasional asynchronous reset pulses.
    repeat (400) begin
      @(posedge clk); #2;
      start = ($urandom_range(0, 3) == 0);
      din   = 8'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #1 rst = 1'b0;
        #1 rst = 1'b1;
      end
    end
    @(posedge clk); #2 start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range 1..32.
REQ-002 Parameter PARITY_EN, default 1; 1 inserts an even-parity bit after the payload, 0 omits it.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  frame request; sampled on the rising edge of clk.
REQ-006 din  input  DATA_W  payload; captured on the same edge that accepts start.
REQ-007 ready  output  1  high when a start on the next edge will be accepted.
REQ-008 x  output  1  serial line driven toward the receiving Moore machine.
REQ-009 done  output  1  high for exactly the single STOP cycle of each frame.

Function
REQ-010 The block SHALL be a Moore machine: x, ready and done decode only from state and datapath registers, with no combinational path from start or din.
REQ-011 The states SHALL be IDLE, START, DATA, PARITY and STOP, encoded in a registered state variable with a combinational next-state block.
REQ-012 IDLE: x=0, ready=1, done=0; start=1 SHALL load din into the shift register, clear the bit counter, and go to START; start=0 SHALL stay in IDLE.
REQ-013 START: x=1 for exactly one cycle, ready=0; the next state SHALL be DATA.
REQ-014 DATA: x = shift-register MSB (payload sent MSB first), ready=0; each cycle SHALL shift left by one and increment the bit counter.
REQ-015 DATA SHALL last exactly DATA_W cycles; after the last bit the next state SHALL be PARITY if PARITY_EN=1, otherwise STOP.
REQ-016 PARITY: x = XOR of all DATA_W bits of the captured payload (even parity), held for one cycle; the next state SHALL be STOP.
REQ-017 STOP: x=0, done=1, ready=1, for one cycle.
REQ-018 In STOP, start=1 SHALL capture din and go directly to START (back-to-back frames, no idle gap); start=0 SHALL return to IDLE.
REQ-019 start asserted in START, DATA or PARITY SHALL be ignored; din SHALL not be re-captured and the frame in progress SHALL be unaffected.
REQ-020 Frame length SHALL be 1 + DATA_W + PARITY_EN + 1 cycles, and START SHALL appear on x in the cycle immediately after the accepting edge.
REQ-021 Parity SHALL be computed from the captured copy of the payload, so changes on din after capture SHALL have no effect.
REQ-022 The bit counter width SHALL be clog2(DATA_W+1) and SHALL not wrap within a frame.
REQ-023 An illegal state encoding SHALL go to IDLE on the next edge.

Reset
REQ-024 When rst=0, the block SHALL immediately, independent of clk, set state=IDLE, x=0, ready=1, done=0, and clear the shift register and bit counter.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no parity or STOP emitted.
REQ-026 After rst is released, the first accepted start SHALL produce a complete, correct frame.

Verification
REQ-027 With DATA_W=8 and PARITY_EN=1: din=8'hA5 with start for one cycle -> x = 1,1,0,1,0,0,1,0,1,0,0 on the 11 cycles after acceptance; done=1 only on the 11th cycle; ready=0 on cycles 1-10.
REQ-028 din=8'h01 with PARITY_EN=1 -> payload 0,0,0,0,0,0,0,1, then parity bit x=1; with PARITY_EN=0 -> frame is 10 cycles long with no parity cycle.
REQ-029 Back-to-back: start held high and din changed to 8'h3C during the STOP cycle of an 8'hA5 frame -> START for 8'h3C on the next cycle, with no IDLE cycle between the frames.
REQ-030 start pulsed and din changed during DATA of an 8'hA5 frame -> the 8'hA5 waveform is unchanged and exactly one frame is sent.
REQ-031 rst driven low during the 4th DATA bit -> x=0, ready=1 and done=0 immediately; the next start with 8'hFF yields 1, eight 1s, 0, 0.
REQ-032 Idle check: 20 cycles with start=0 after reset -> x=0, ready=1, done=0 throughout.
